// File: rtl/feinv.sv
// Modular inverse over GF(2^255-19) via Fermat: out = a^(p-2) mod p.
// Left-to-right square-and-multiply driven through a single shared femul.
module feinv (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         start,
  input  logic [254:0] a,
  output logic         busy,
  output logic         done,
  output logic [254:0] out
);

  localparam int unsigned W  = 255;
  localparam int unsigned IW = 8;
  // p-2 = 2^255-21: every bit set except bits 2 and 4
  localparam logic [W-1:0] EXP_BITS = {{247{1'b1}}, 8'heb};

  typedef enum logic [2:0] {
    IDLE, SQ_ISSUE, SQ_WAIT, MUL_ISSUE, MUL_WAIT, FINISH
  } state_t;

  state_t          state, state_d;
  logic [W-1:0]    base, base_d;
  logic [W-1:0]    acc, acc_d;
  logic [IW-1:0]   idx, idx_d;
  logic [W-1:0]    out_d;
  logic            busy_d, done_d;
  logic            fm_start, fm_start_d;
  logic            fm_done;
  logic [W-1:0]    fm_out;
  logic [W-1:0]    fm_b_c;
  logic            last_bit_c;

  assign fm_b_c     = (state == MUL_ISSUE || state == MUL_WAIT) ? base : acc;
  assign last_bit_c = (idx == IW'(0));

  femul u_femul (
    .clock (clock),
    .start (fm_start),
    .a     (acc),
    .b     (fm_b_c),
    .done  (fm_done),
    .out   (fm_out)
  );

  // State register and datapath registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      base     <= '0;
      acc      <= '0;
      idx      <= '0;
      out      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      fm_start <= 1'b0;
    end else begin
      state    <= state_d;
      base     <= base_d;
      acc      <= acc_d;
      idx      <= idx_d;
      out      <= out_d;
      busy     <= busy_d;
      done     <= done_d;
      fm_start <= fm_start_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:      if (start) state_d = SQ_ISSUE;
      SQ_ISSUE:  state_d = SQ_WAIT;
      SQ_WAIT: begin
        if (fm_done) begin
          if (EXP_BITS[idx]) state_d = MUL_ISSUE;
          else               state_d = last_bit_c ? FINISH : SQ_ISSUE;
        end
      end
      MUL_ISSUE: state_d = MUL_WAIT;
      MUL_WAIT:  if (fm_done) state_d = last_bit_c ? FINISH : SQ_ISSUE;
      FINISH:    state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Datapath and output next values; femul start is high only while in an issue state
  always_comb begin
    base_d     = base;
    acc_d      = acc;
    idx_d      = idx;
    out_d      = out;
    busy_d     = busy;
    done_d     = done;
    fm_start_d = (state_d == SQ_ISSUE) || (state_d == MUL_ISSUE);
    unique case (state)
      IDLE: begin
        if (start) begin
          base_d = a;
          acc_d  = W'(1);
          idx_d  = IW'(254);
          done_d = 1'b0;
          busy_d = 1'b1;
        end
      end
      SQ_WAIT: begin
        if (fm_done) begin
          acc_d = fm_out;
          if (!EXP_BITS[idx] && !last_bit_c) idx_d = idx - IW'(1);
        end
      end
      MUL_WAIT: begin
        if (fm_done) begin
          acc_d = fm_out;
          if (!last_bit_c) idx_d = idx - IW'(1);
        end
      end
      FINISH: begin
        out_d  = acc;
        done_d = 1'b1;
        busy_d = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// Multiplier mod 2^255-19, 64-bit digit-serial, MSB digit first.
// A start always restarts it, abandoning any operation in flight.
module femul (
  input  logic         clock,
  input  logic         start,
  input  logic [254:0] a,
  input  logic [254:0] b,
  output logic         done,
  output logic [254:0] out
);

  localparam int unsigned W  = 255;
  localparam int unsigned W1 = W + 1;
  localparam int unsigned DW = 64;
  localparam int unsigned ND = 4;
  localparam int unsigned AW = ND * DW;
  localparam int unsigned SW = W + DW + 1;
  localparam int unsigned CW = 2;
  localparam logic [W1-1:0] P_EXT = {1'b0, {247{1'b1}}, 8'hed};

  logic [AW-1:0] ad;
  logic [W-1:0]  bq;
  logic [CW-1:0] cnt;
  logic          run;

  logic [DW-1:0] dig_c;
  logic [SW-1:0] sum_c;
  logic [DW:0]   hi_c;
  logic [W-1:0]  lo_c;
  logic [W1-1:0] t1_c, t2_c;
  logic [W-1:0]  res_c;

  // One step: out*2^64 + b*digit, folded twice with 2^255 = 19, then a final conditional subtract
  always_comb begin
    dig_c = ad[AW-1 -: DW];
    sum_c = {1'b0, out, DW'(0)} + SW'(bq) * SW'(dig_c);
    hi_c  = sum_c[SW-1:W];
    lo_c  = sum_c[W-1:0];
    t1_c  = W1'(lo_c) + W1'(hi_c) * W1'(19);
    t2_c  = W1'(t1_c[W-1:0]) + (t1_c[W] ? W1'(19) : W1'(0));
    res_c = (t2_c >= P_EXT) ? W'(t2_c - P_EXT) : W'(t2_c);
  end

  always_ff @(posedge clock) begin
    if (start) begin
      ad   <= {1'b0, a};
      bq   <= b;
      out  <= '0;
      cnt  <= '0;
      run  <= 1'b1;
      done <= 1'b0;
    end else if (run) begin
      out <= res_c;
      ad  <= ad << DW;
      cnt <= cnt + CW'(1);
      if (cnt == CW'(ND - 1)) begin
        run  <= 1'b0;
        done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_feinv.sv
// Bench for feinv: table of operands/expected inverses with a result scoreboard,
// plus sequences for mid-run start, start during the final cycle and mid-run reset.
module tb_feinv;

  localparam logic [254:0] P    = {{247{1'b1}}, 8'hed};
  localparam logic [254:0] PM1  = {{247{1'b1}}, 8'hec};
  localparam logic [254:0] INV2 = {1'b0, {250{1'b1}}, 4'h7};
  localparam logic [255:0] INV3_W =
    256'h5555555555555555_5555555555555555_5555555555555555_5555555555555549;
  localparam int TMO = 8000;

  logic         clock;
  logic         reset_n;
  logic         start;
  logic [254:0] a;
  logic         busy;
  logic         done;
  logic [254:0] out;

  feinv dut (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (start),
    .a       (a),
    .busy    (busy),
    .done    (done),
    .out     (out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;
  logic [254:0] sb_q[$];

  // Observers: femul start pulses, back-to-back starts, done rising edges
  int   n_fmstart = 0;
  int   n_consec  = 0;
  int   n_rise    = 0;
  logic fs_q      = 1'b0;
  logic done_q    = 1'b0;
  always @(negedge clock) begin
    if (dut.fm_start) begin
      n_fmstart = n_fmstart + 1;
      if (fs_q) n_consec = n_consec + 1;
    end
    fs_q = dut.fm_start;
    if (done && !done_q) n_rise = n_rise + 1;
    done_q = done;
  end

  function automatic logic [254:0] mmul(input logic [254:0] x, input logic [254:0] y);
    logic [511:0] t;
    t = 512'(x) * 512'(y);
    t = t % 512'(P);
    return t[254:0];
  endfunction

  // Right-to-left exponentiation by p-2
  function automatic logic [254:0] minv(input logic [254:0] x);
    logic [254:0] e, r, bb;
    e  = P - 255'd2;
    r  = 255'd1;
    bb = x;
    for (int i = 0; i < 255; i++) begin
      if (e[i]) r = mmul(r, bb);
      bb = mmul(bb, bb);
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [254:0] got, input logic [254:0] want);
    n_cmp = n_cmp + 1;
    if (got !== want) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  task automatic run_inv(input logic [254:0] av, input logic [254:0] ev, input logic mid,
                         input logic [254:0] mid_a, input string tag, output int lat);
    int s0, r0, c0, cyc;
    logic [254:0] want;
    sb_q.push_back(ev);
    s0 = n_fmstart;
    r0 = n_rise;
    c0 = n_consec;
    @(negedge clock);
    a     = av;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    chk({tag, " busy after start"}, 255'(busy), 255'd1);
    cyc = 0;
    while (!done && cyc < TMO) begin
      @(negedge clock);
      cyc = cyc + 1;
      if (mid && cyc == 400) begin
        start = 1'b1;
        a     = mid_a;
      end
      if (mid && cyc == 401) start = 1'b0;
    end
    lat  = cyc;
    want = sb_q.pop_front();
    chk({tag, " done before timeout"}, 255'(done), 255'd1);
    chk({tag, " out"}, out, want);
    chk({tag, " busy at done"}, 255'(busy), 255'd0);
    if (av != '0) chk({tag, " a*out mod p"}, mmul(av, out), 255'd1);
    repeat (4) @(negedge clock);
    chk({tag, " done held"}, 255'(done), 255'd1);
    chk({tag, " out held"}, out, want);
    chk({tag, " femul ops"}, 255'(n_fmstart - s0), 255'd508);
    chk({tag, " done rises"}, 255'(n_rise - r0), 255'd1);
    chk({tag, " back-to-back starts"}, 255'(n_consec - c0), 255'd0);
  endtask

  typedef struct {
    logic [254:0] a;
    logic [254:0] exp;
    logic         mid;
    logic [254:0] mid_a;
    string        tag;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [255:0] rw;
    logic [254:0] rnd;
    int lat, lat2, r0;

    reset_n = 1'b0;
    start   = 1'b0;
    a       = '0;

    rw  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    rnd = rw[254:0];
    if (rnd >= P) rnd = rnd - P;
    vecs[0] = '{255'd1, 255'd1,     1'b0, '0,     "a=1"};
    vecs[1] = '{255'd2, INV2,       1'b0, '0,     "a=2"};
    vecs[2] = '{255'd0, 255'd0,     1'b0, '0,     "a=0"};
    vecs[3] = '{PM1,    PM1,        1'b0, '0,     "a=p-1"};
    vecs[4] = '{255'd3, INV3_W[254:0], 1'b1, 255'd5, "a=3 restart ignored"};
    vecs[5] = '{rnd,    minv(rnd),  1'b0, '0,     "a=random"};

    repeat (3) @(negedge clock);
    chk("reset busy", 255'(busy), 255'd0);
    chk("reset done", 255'(done), 255'd0);
    chk("reset out", out, 255'd0);
    reset_n = 1'b1;
    repeat (5) @(negedge clock);
    chk("post-reset idle busy", 255'(busy), 255'd0);
    chk("post-reset idle done", 255'(done), 255'd0);
    chk("post-reset idle out", out, 255'd0);

    for (int i = 0; i < 6; i++)
      run_inv(vecs[i].a, vecs[i].exp, vecs[i].mid, vecs[i].mid_a, vecs[i].tag, lat);

    // Start held during the FINISH cycle must be ignored
    run_inv(255'd2, INV2, 1'b0, '0, "a=2 timing", lat);
    if (lat > 1 && lat < TMO) begin
      sb_q.push_back(INV2);
      @(negedge clock);
      a     = 255'd2;
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      for (int k = 1; k < lat; k++) @(negedge clock);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      chk("finish-cycle done", 255'(done), 255'd1);
      chk("finish-cycle out", out, sb_q.pop_front());
      repeat (5) @(negedge clock);
      chk("finish-cycle start ignored busy", 255'(busy), 255'd0);
      chk("finish-cycle start ignored done", 255'(done), 255'd1);
    end else begin
      chk("latency measured", 255'(lat), 255'(TMO - 1));
    end

    // Reset midway through a=7, then a fresh a=2 run
    @(negedge clock);
    a     = 255'd7;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (1000) @(negedge clock);
    chk("mid-run busy before reset", 255'(busy), 255'd1);
    reset_n = 1'b0;
    #1;
    chk("abort busy", 255'(busy), 255'd0);
    chk("abort done", 255'(done), 255'd0);
    chk("abort out", out, 255'd0);
    chk("abort femul start", 255'(dut.fm_start), 255'd0);
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    r0 = n_rise;
    repeat (30) @(negedge clock);
    chk("after abort busy", 255'(busy), 255'd0);
    chk("after abort done", 255'(done), 255'd0);
    chk("after abort out", out, 255'd0);
    chk("after abort no done", 255'(n_rise - r0), 255'd0);
    run_inv(255'd2, INV2, 1'b0, '0, "a=2 after abort", lat2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
